// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and retry limit.
// The keyboard receiver may import this too.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE,
    FINISH
  } ps2_state_t;

  localparam int FRAME_BITS  = 10;
  localparam int ACK_EDGE    = 11;
  localparam int MAX_RETRIES = 2;

  // Bits sent on device clock edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad with a one-cycle falling-edge pulse.
// Flops reset high (idle bus level) so reset release never produces a false edge.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter over open-drain clock/data (OE=1 pulls low).
// Optional PS2_HOST_TX_RESEND_EN: retry a failed transfer up to MAX_RETRIES times before reporting.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE,
  output logic       BUSY,
  output logic       RX_INHIBIT,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       TIMEOUT_ERR
);

`ifdef PS2_HOST_TX_RESEND_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  ps2_state_t            state;
  logic [31:0]           cnt;
  logic [31:0]           tocnt;
  logic [FRAME_BITS-1:0] frame;
  logic [3:0]            edges;
  logic [1:0]            retries;
  logic                  nack;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;
  logic can_retry;

  ps2_sync_edge u_clk_sync (
    .clk   (CLK),
    .rst   (RST),
    .raw   (PS2CLK_IN),
    .level (clk_sync),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (CLK),
    .rst   (RST),
    .raw   (PS2DATA_IN),
    .level (data_sync),
    .fall  (data_fall_unused)
  );

  assign can_retry  = (retries != 2'(RETRY_LIMIT));
  assign RX_INHIBIT = BUSY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      tocnt       <= '0;
      frame       <= '0;
      edges       <= '0;
      retries     <= '0;
      nack        <= 1'b0;
      PS2CLK_OE   <= 1'b0;
      PS2DATA_OE  <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ACK_ERR     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (TX_START) begin
            frame       <= build_frame(TX_DATA);
            ACK_ERR     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            BUSY        <= 1'b1;
            retries     <= '0;
            nack        <= 1'b0;
            cnt         <= '0;
            PS2CLK_OE   <= 1'b1;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
            cnt        <= '0;
            PS2DATA_OE <= 1'b1;
            state      <= REQ;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        REQ: begin
          if (cnt == 32'(REQ_CYCLES - 1)) begin
            PS2CLK_OE <= 1'b0;
            tocnt     <= '0;
            edges     <= '0;
            state     <= DATA;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DATA, ACK, WAIT_IDLE: begin
          tocnt <= tocnt + 32'd1;
          // Timeout wins over any edge arriving in the same cycle.
          if (tocnt == 32'(TIMEOUT_CYCLES - 1)) begin
            if (can_retry) begin
              retries    <= retries + 2'd1;
              nack       <= 1'b0;
              cnt        <= '0;
              PS2CLK_OE  <= 1'b1;
              PS2DATA_OE <= 1'b0;
              state      <= INHIBIT;
            end else begin
              PS2CLK_OE   <= 1'b0;
              PS2DATA_OE  <= 1'b0;
              ACK_ERR     <= nack;
              TIMEOUT_ERR <= ~nack;
              state       <= FINISH;
            end
          end else if (state == DATA) begin
            if (clk_fall) begin
              PS2DATA_OE <= ~frame[edges];
              edges      <= edges + 4'd1;
              if (edges == 4'(FRAME_BITS - 1)) state <= ACK;
            end
          end else if (state == ACK) begin
            if (clk_fall && edges == 4'(ACK_EDGE - 1)) begin
              edges <= edges + 4'd1;
              nack  <= data_sync;
              state <= WAIT_IDLE;
            end
          end else begin
            if (clk_sync && data_sync) begin
              if (nack && can_retry) begin
                retries    <= retries + 2'd1;
                nack       <= 1'b0;
                cnt        <= '0;
                PS2CLK_OE  <= 1'b1;
                PS2DATA_OE <= 1'b0;
                state      <= INHIBIT;
              end else begin
                ACK_ERR <= nack;
                state   <= FINISH;
              end
            end
          end
        end

        FINISH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 keyboard on open-drain lines, parity from a bit count.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int REQC = 4;
  localparam int TMO = 5000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_START = 1'b0;
  logic       PS2CLK_OE, PS2DATA_OE, BUSY, RX_INHIBIT, DONE, ACK_ERR, TIMEOUT_ERR;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  wire  clk_line  = dev_clk & ~PS2CLK_OE;
  wire  data_line = dev_data & ~PS2DATA_OE;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic last_ack = 1'b0;
  logic last_to = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQC), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_START(TX_START),
    .PS2CLK_IN(clk_line), .PS2DATA_IN(data_line),
    .PS2CLK_OE(PS2CLK_OE), .PS2DATA_OE(PS2DATA_OE), .BUSY(BUSY), .RX_INHIBIT(RX_INHIBIT),
    .DONE(DONE), .ACK_ERR(ACK_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (DONE) begin
      done_cnt++;
      last_ack = ACK_ERR;
      last_to  = TIMEOUT_ERR;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic odd_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge CLK);
    TX_DATA  = b;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
  endtask

  // Keyboard: waits for request-to-send, then clocks 10 bits plus the ACK clock.
  task automatic device_run(input int stop_edge, input bit give_ack,
                            output logic [7:0] got, output logic par, output logic stp,
                            output logic st, output int inh, output int req, output bit ok);
    bit seen_req = 0;
    bit released = 0;
    got = '0; par = 1'b0; stp = 1'b0; st = 1'b1; inh = 0; req = 0; ok = 0;
    for (int t = 0; t < 2000; t++) begin
      if (PS2CLK_OE && !PS2DATA_OE) inh++;
      if (PS2CLK_OE && PS2DATA_OE) begin req++; seen_req = 1; end
      if (seen_req && !PS2CLK_OE) begin released = 1; break; end
      @(negedge CLK);
    end
    if (!released) begin
      $display("FAIL device: no request-to-send/clock release seen");
      return;
    end
    ok = 1;
    repeat (20) @(negedge CLK);
    st = data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == stop_edge) return;
      repeat (40) @(negedge CLK);
      if (k <= 8) got[k-1] = data_line;
      else if (k == 9) par = data_line;
      else stp = data_line;
      dev_clk = 1'b1;
      repeat (40) @(negedge CLK);
    end
    dev_data = give_ack ? 1'b0 : 1'b1;
    repeat (20) @(negedge CLK);
    dev_clk = 1'b0;
    repeat (40) @(negedge CLK);
    dev_clk = 1'b1;
    repeat (10) @(negedge CLK);
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      if (done_cnt != d0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if ({PS2CLK_OE, PS2DATA_OE, BUSY, RX_INHIBIT} !== 4'b0) begin
      errors++; $display("FAIL reset_lines got %b want 0000", {PS2CLK_OE, PS2DATA_OE, BUSY, RX_INHIBIT}); end
    checks++; if ({DONE, ACK_ERR, TIMEOUT_ERR} !== 3'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000", {DONE, ACK_ERR, TIMEOUT_ERR}); end
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    checks++; if ({PS2CLK_OE, PS2DATA_OE, BUSY, DONE} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got %b want 0000", {PS2CLK_OE, PS2DATA_OE, BUSY, DONE}); end
  endtask

  task automatic test_frame(input logic [7:0] b, input bit give_ack, input bit check_times);
    logic [7:0] got; logic par, stp, st; int inh, req; bit ok, dok;
    int d0 = done_cnt;
    start_tx(b);
    checks++; if ({BUSY, RX_INHIBIT} !== 2'b11) begin
      errors++; $display("FAIL busy_%h got %b want 11", b, {BUSY, RX_INHIBIT}); end
    device_run(0, give_ack, got, par, stp, st, inh, req, ok);
    checks++; if (!ok) begin errors++; $display("FAIL release_%h got none want release", b); end
    if (check_times) begin
      checks++; if (inh != INH || req != REQC) begin
        errors++; $display("FAIL timing_%h got inh %0d req %0d want %0d %0d", b, inh, req, INH, REQC); end
    end
    checks++; if (st !== 1'b0 || stp !== 1'b1) begin
      errors++; $display("FAIL start_stop_%h got %b%b want 01", b, st, stp); end
    checks++; if (got !== b) begin errors++; $display("FAIL data_%h got %h want %h", b, got, b); end
    checks++; if (par !== odd_parity(b)) begin
      errors++; $display("FAIL parity_%h got %b want %b", b, par, odd_parity(b)); end
    wait_done(d0, dok);
    checks++; if (!dok) begin errors++; $display("FAIL done_%h got no DONE want pulse", b); end
    repeat (20) @(negedge CLK);
    checks++; if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL done_count_%h got %0d want 1", b, done_cnt - d0); end
    checks++; if (last_ack !== !give_ack || last_to !== 1'b0) begin
      errors++; $display("FAIL errs_%h got ack %b to %b want %b 0", b, last_ack, last_to, !give_ack); end
    checks++; if ({BUSY, PS2CLK_OE, PS2DATA_OE} !== 3'b0) begin
      errors++; $display("FAIL end_lines_%h got %b want 000", b, {BUSY, PS2CLK_OE, PS2DATA_OE}); end
  endtask

  task automatic test_nack();
    logic [7:0] b = 8'($urandom_range(0, 255));
    test_frame(b, 1'b0, 1'b0);
    start_tx(8'hF4);
    checks++; if (ACK_ERR !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", ACK_ERR); end
    begin
      logic [7:0] got; logic par, stp, st; int inh, req; bit ok, dok;
      int d0 = done_cnt;
      device_run(0, 1'b1, got, par, stp, st, inh, req, ok);
      wait_done(d0, dok);
      checks++; if (!dok || got !== 8'hF4 || last_ack !== 1'b0) begin
        errors++; $display("FAIL after_nack got done %b data %h ack %b want 1 f4 0", dok, got, last_ack); end
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int n = 0;
    bit seen_req = 0, rel = 0, dok = 0;
    start_tx(8'h3C);
    for (int t = 0; t < 500; t++) begin
      if (PS2CLK_OE && PS2DATA_OE) seen_req = 1;
      if (seen_req && !PS2CLK_OE) begin rel = 1; break; end
      @(negedge CLK);
    end
    for (int t = 0; t < 6000 && rel; t++) begin
      @(negedge CLK);
      n++;
      if (done_cnt != d0) begin dok = 1; break; end
    end
    checks++; if (!dok || n < TMO - 2 || n > TMO + 3) begin
      errors++; $display("FAIL timeout_delay got %0d (done %b) want about %0d", n, dok, TMO); end
    checks++; if (last_to !== 1'b1 || last_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_flags got to %b ack %b want 1 0", last_to, last_ack); end
    @(negedge CLK);
    checks++; if ({PS2CLK_OE, PS2DATA_OE, BUSY} !== 3'b0) begin
      errors++; $display("FAIL timeout_lines got %b want 000", {PS2CLK_OE, PS2DATA_OE, BUSY}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b = 8'($urandom_range(0, 255));
    logic [7:0] got; logic par, stp, st; int inh, req; bit ok, dok;
    int d0;
    if (b == 8'h55) b = 8'hAA;
    d0 = done_cnt;
    start_tx(b);
    repeat (5) @(negedge CLK);
    TX_DATA = 8'h55; TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
    device_run(0, 1'b1, got, par, stp, st, inh, req, ok);
    wait_done(d0, dok);
    repeat (200) @(negedge CLK);
    checks++; if (got !== b || par !== odd_parity(b)) begin
      errors++; $display("FAIL busy_start data got %h/%b want %h/%b", got, par, b, odd_parity(b)); end
    checks++; if (done_cnt != d0 + 1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL busy_start dones got %0d busy %b want 1 0", done_cnt - d0, BUSY); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got; logic par, stp, st; int inh, req; bit ok;
    int d0 = done_cnt;
    start_tx(8'h96);
    device_run(5, 1'b1, got, par, stp, st, inh, req, ok);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if ({PS2CLK_OE, PS2DATA_OE, BUSY} !== 3'b0) begin
      errors++; $display("FAIL async_reset got %b want 000", {PS2CLK_OE, PS2DATA_OE, BUSY}); end
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (20) @(negedge CLK);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    checks++; if (done_cnt != d0) begin
      errors++; $display("FAIL reset_no_done got %0d want 0", done_cnt - d0); end
    test_frame(8'h5A, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frame(8'hED, 1'b1, 1'b1);
    test_frame(8'hF4, 1'b1, 1'b1);
    test_frame(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) test_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
